// File: rtl/aes_job_ctrl.sv
// Job controller for the AES encrypt/decrypt cores: round-robin request arbitration,
// round sequencing, a reversed round-key file for decryption, and one response port.
module aes_job_ctrl #(
   parameter int ROUNDS = 10,
   parameter int DW     = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enc_valid,
   output logic          enc_ready,
   input  logic [DW-1:0] enc_pt,
   input  logic [DW-1:0] enc_key,
   input  logic          dec_valid,
   output logic          dec_ready,
   input  logic [DW-1:0] dec_ct,
   output logic          core_enc_run,
   output logic [3:0]    core_enc_round,
   output logic [DW-1:0] core_enc_pt,
   output logic [DW-1:0] core_enc_key,
   input  logic [DW-1:0] core_enc_rkey,
   input  logic [7:0]    core_enc_sbox,
   input  logic [DW-1:0] core_enc_res,
   output logic          core_dec_run,
   output logic [3:0]    core_dec_round,
   output logic [DW-1:0] core_dec_ct,
   output logic [DW-1:0] core_dec_key,
   output logic [7:0]    core_dec_sbox,
   input  logic [DW-1:0] core_dec_res,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_is_dec,
   output logic          rsp_match,
   output logic          keys_valid,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENC     = 3'd1,
      ENC_FIN = 3'd2,
      DEC     = 3'd3,
      DEC_FIN = 3'd4,
      RESP    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    round_q, round_d;
   logic          prio_dec_q;
   logic [DW-1:0] key_file [ROUNDS];
   logic [DW-1:0] pt_q, key_q;
   logic          enc_elig, dec_elig, grant_enc, grant_dec;
   logic          last_enc, last_dec;
   logic [3:0]    dec_idx;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // ready is combinational, never waits on anything but state/arbitration, valid must hold until then.
   assign enc_elig  = enc_valid;
   assign dec_elig  = dec_valid & keys_valid;
   assign grant_enc = enc_elig & (~dec_elig | ~prio_dec_q);
   assign grant_dec = dec_elig & (~enc_elig | prio_dec_q);
   assign enc_ready = (state_q == IDLE) & grant_enc;
   assign dec_ready = (state_q == IDLE) & grant_dec;

   assign last_enc = (round_q == 4'(ROUNDS - 1));
   assign last_dec = (round_q == 4'(ROUNDS));

   assign core_enc_run   = (state_q == ENC) | (state_q == ENC_FIN);
   assign core_dec_run   = (state_q == DEC) | (state_q == DEC_FIN);
   assign core_enc_round = (state_q == ENC) ? round_q : 4'd0;
   assign core_dec_round = (state_q == DEC) ? round_q : 4'd0;
   assign core_enc_pt    = pt_q;
   assign core_enc_key   = key_q;
   assign rsp_valid      = (state_q == RESP);
   assign state_dbg      = state_q;

   // Decryption walks the key file backwards and finishes with the original cipher key.
   assign dec_idx      = (round_q < 4'(ROUNDS)) ? (4'(ROUNDS - 1) - round_q) : 4'd0;
   assign core_dec_key = (round_q < 4'(ROUNDS)) ? key_file[dec_idx] : key_q;

   always_comb begin
      state_d = state_q;
      round_d = 4'd0;
      case (state_q)
         IDLE: begin
            if (enc_ready)      state_d = ENC;
            else if (dec_ready) state_d = DEC;
         end
         ENC: begin
            if (last_enc) state_d = ENC_FIN;
            else          round_d = round_q + 4'd1;
         end
         ENC_FIN: state_d = RESP;
         DEC: begin
            if (last_dec) state_d = DEC_FIN;
            else          round_d = round_q + 4'd1;
         end
         DEC_FIN: state_d = RESP;
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         round_q       <= 4'd0;
         prio_dec_q    <= 1'b0;
         keys_valid    <= 1'b0;
         rsp_data      <= '0;
         rsp_is_dec    <= 1'b0;
         rsp_match     <= 1'b0;
         core_dec_sbox <= 8'd0;
         core_dec_ct   <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         if (enc_ready | dec_ready) prio_dec_q <= ~prio_dec_q;
         if (enc_ready) keys_valid <= 1'b0;
         if (dec_ready) core_dec_ct <= dec_ct;
         if (state_q == ENC_FIN) begin
            rsp_data      <= core_enc_res;
            core_dec_sbox <= core_enc_sbox;
            keys_valid    <= 1'b1;
            rsp_is_dec    <= 1'b0;
            rsp_match     <= 1'b0;
         end
         if (state_q == DEC_FIN) begin
            rsp_data   <= core_dec_res;
            rsp_is_dec <= 1'b1;
            rsp_match  <= (core_dec_res == pt_q);
         end
      end
   end

   // Key file and job operands are qualified by keys_valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (enc_ready) begin
         pt_q  <= enc_pt;
         key_q <= enc_key;
      end
      if (state_q == ENC) key_file[round_q] <= core_enc_rkey;
   end

endmodule

// File: tb/tb_aes_job_ctrl.sv
// Directed bench for aes_job_ctrl with a behavioural stand-in for the AES cores.
module tb_aes_job_ctrl;

   localparam int DW = 128;
   localparam logic [DW-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [DW-1:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [DW-1:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [DW-1:0] KX   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [DW-1:0] PT2  = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [DW-1:0] CT2  = 128'h5566778899aabbccddeeff0011223344;
   localparam logic [DW-1:0] BADP = PT ^ 128'h80;

   logic          clk = 1'b0;
   logic          rst;
   logic          enc_valid, enc_ready, dec_valid, dec_ready;
   logic [DW-1:0] enc_pt, enc_key, dec_ct;
   logic          core_enc_run, core_dec_run;
   logic [3:0]    core_enc_round, core_dec_round;
   logic [DW-1:0] core_enc_pt, core_enc_key, core_enc_rkey, core_enc_res;
   logic [7:0]    core_enc_sbox, core_dec_sbox;
   logic [DW-1:0] core_dec_ct, core_dec_key, core_dec_res;
   logic          rsp_valid, rsp_ready, rsp_is_dec, rsp_match, keys_valid;
   logic [DW-1:0] rsp_data;
   logic [2:0]    state_dbg;

   logic [DW-1:0] rk [0:10];
   logic [DW-1:0] key_xor;
   logic [DW-1:0] exp_q [$];
   int            tests = 0;
   int            fails = 0;

   aes_job_ctrl dut (
      .clk(clk), .rst(rst),
      .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_pt(enc_pt), .enc_key(enc_key),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_ct(dec_ct),
      .core_enc_run(core_enc_run), .core_enc_round(core_enc_round),
      .core_enc_pt(core_enc_pt), .core_enc_key(core_enc_key),
      .core_enc_rkey(core_enc_rkey), .core_enc_sbox(core_enc_sbox), .core_enc_res(core_enc_res),
      .core_dec_run(core_dec_run), .core_dec_round(core_dec_round), .core_dec_ct(core_dec_ct),
      .core_dec_key(core_dec_key), .core_dec_sbox(core_dec_sbox), .core_dec_res(core_dec_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_is_dec(rsp_is_dec), .rsp_match(rsp_match), .keys_valid(keys_valid),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // encrypt core model: round r produces round key r+1 of the schedule
   assign core_enc_rkey = (core_enc_round < 4'd10) ? (rk[core_enc_round + 4'd1] ^ key_xor) : '0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_dec_keys(input logic [DW-1:0] kx, input logic [DW-1:0] ckey);
      exp_q.delete();
      for (int r = 0; r < 10; r++) exp_q.push_back(rk[10 - r] ^ kx);
      exp_q.push_back(ckey);
   endtask

   // Called in cycle 1 after a handshake; returns in the cycle rsp_valid is seen.
   task automatic wait_rsp(input bit is_dec, output int n);
      n = 1;
      while (rsp_valid !== 1'b1 && n < 40) begin
         if (is_dec && n <= 11) begin
            chk("dec_round", core_dec_round, n - 1);
            chk("dec_key", core_dec_key, exp_q.pop_front());
            chk("dec_run", core_dec_run, 1);
         end
         if (!is_dec && n <= 10) begin
            chk("enc_round", core_enc_round, n - 1);
            chk("enc_run", core_enc_run, 1);
         end
         step();
         n++;
      end
      if (is_dec) chk("dec_latency", n, 13);
      else        chk("enc_latency", n, 12);
   endtask

   initial begin
      int n;
      rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
      rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      rst = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; rsp_ready = 1'b1;
      enc_pt = '0; enc_key = '0; dec_ct = '0; key_xor = '0;
      core_enc_res = '0; core_enc_sbox = 8'd0; core_dec_res = '0;
      repeat (3) step();

      // reset values
      chk("rst_enc_ready", enc_ready, 0);
      chk("rst_dec_ready", dec_ready, 0);
      chk("rst_enc_run", core_enc_run, 0);
      chk("rst_dec_run", core_dec_run, 0);
      chk("rst_enc_round", core_enc_round, 0);
      chk("rst_dec_round", core_dec_round, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_is_dec", rsp_is_dec, 0);
      chk("rst_rsp_match", rsp_match, 0);
      chk("rst_keys_valid", keys_valid, 0);
      chk("rst_dec_sbox", core_dec_sbox, 0);
      chk("rst_state", state_dbg, 0);
      rst = 1'b1;
      step();

      // encrypt interrupted by reset in round 5
      enc_pt = PT; enc_key = KEY; enc_valid = 1'b1;
      #1 chk("abort_enc_ready", enc_ready, 1);
      step();
      enc_valid = 1'b0;
      repeat (5) step();
      chk("abort_round5", core_enc_round, 5);
      rst = 1'b0;
      #1;
      chk("abort_enc_run", core_enc_run, 0);
      chk("abort_enc_round", core_enc_round, 0);
      chk("abort_keys_valid", keys_valid, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_state", state_dbg, 0);
      step();
      rst = 1'b1;
      dec_valid = 1'b1; dec_ct = CT;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("nokey_dec_ready", dec_ready, 0);
         chk("nokey_keys_valid", keys_valid, 0);
         step();
      end

      // FIPS-197 encrypt, decrypt also requesting but not eligible
      enc_valid = 1'b1; enc_pt = PT; enc_key = KEY;
      core_enc_res = CT; core_enc_sbox = 8'h5a; key_xor = '0;
      #1;
      chk("fips_enc_ready", enc_ready, 1);
      chk("fips_dec_blocked", dec_ready, 0);
      step();
      enc_valid = 1'b0; dec_valid = 1'b0;
      chk("fips_core_pt", core_enc_pt, PT);
      chk("fips_core_key", core_enc_key, KEY);
      chk("fips_keys_cleared", keys_valid, 0);
      wait_rsp(1'b0, n);
      chk("fips_ct", rsp_data, CT);
      chk("fips_is_dec", rsp_is_dec, 0);
      chk("fips_match", rsp_match, 0);
      chk("fips_keys_valid", keys_valid, 1);
      chk("fips_sbox", core_dec_sbox, 8'h5a);
      step();
      chk("fips_idle", state_dbg, 0);
      chk("fips_rsp_done", rsp_valid, 0);

      // both requesting with keys: decrypt wins first, then encrypt
      enc_valid = 1'b1; dec_valid = 1'b1; dec_ct = CT; core_dec_res = PT;
      load_dec_keys('0, KEY);
      #1;
      chk("sim1_dec_ready", dec_ready, 1);
      chk("sim1_enc_ready", enc_ready, 0);
      step();
      chk("sim1_dec_ct", core_dec_ct, CT);
      wait_rsp(1'b1, n);
      chk("dec_pt", rsp_data, PT);
      chk("dec_is_dec", rsp_is_dec, 1);
      chk("dec_match", rsp_match, 1);
      chk("resp_enc_ready", enc_ready, 0);
      chk("resp_dec_ready", dec_ready, 0);
      step();
      chk("sim2_enc_ready", enc_ready, 1);
      chk("sim2_dec_ready", dec_ready, 0);
      step();
      enc_valid = 1'b0; dec_valid = 1'b0;
      chk("sim2_keys_cleared", keys_valid, 0);
      wait_rsp(1'b0, n);
      chk("sim2_ct", rsp_data, CT);
      step();

      // wrong ciphertext, response held off for 20 cycles
      dec_valid = 1'b1; dec_ct = CT ^ 128'h1; core_dec_res = BADP; rsp_ready = 1'b0;
      load_dec_keys('0, KEY);
      #1 chk("bad_dec_ready", dec_ready, 1);
      step();
      dec_valid = 1'b0;
      wait_rsp(1'b1, n);
      chk("bad_match", rsp_match, 0);
      chk("bad_data", rsp_data, BADP);
      enc_valid = 1'b1; dec_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_data", rsp_data, BADP);
         chk("bp_enc_ready", enc_ready, 0);
         chk("bp_dec_ready", dec_ready, 0);
         step();
      end
      enc_valid = 1'b0; dec_valid = 1'b0; rsp_ready = 1'b1;
      step();
      chk("bp_idle", state_dbg, 0);
      chk("bp_rsp_done", rsp_valid, 0);

      // key overwrite: decrypt stalls behind a new encrypt, then uses the new schedule
      enc_valid = 1'b1; dec_valid = 1'b1;
      enc_pt = PT2; enc_key = KEY ^ KX; key_xor = KX;
      core_enc_res = CT2; core_enc_sbox = 8'hc3; dec_ct = CT2; core_dec_res = PT2;
      #1;
      chk("ovw_enc_ready", enc_ready, 1);
      chk("ovw_dec_ready", dec_ready, 0);
      step();
      enc_valid = 1'b0;
      chk("ovw_keys_cleared", keys_valid, 0);
      #1 chk("ovw_dec_stall", dec_ready, 0);
      wait_rsp(1'b0, n);
      chk("ovw_ct", rsp_data, CT2);
      chk("ovw_sbox", core_dec_sbox, 8'hc3);
      chk("ovw_dec_stall_resp", dec_ready, 0);
      load_dec_keys(KX, KEY ^ KX);
      step();
      chk("ovw_dec_grant", dec_ready, 1);
      step();
      dec_valid = 1'b0;
      wait_rsp(1'b1, n);
      chk("ovw_pt", rsp_data, PT2);
      chk("ovw_match", rsp_match, 1);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
